// File: rtl/scan_hex_pkg.sv
// Shared types and constants for the scan_hex UART text parser.
package scan_hex_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0]  DIGIT_MAX     = CNT_W'(8);
    localparam logic [CHAR_W-1:0] CH_CR         = 8'h0D;
    localparam logic [CHAR_W-1:0] CH_SPACE      = 8'h20;
    localparam logic [CHAR_W-1:0] CH_UNDERSCORE = 8'h5F;
    localparam logic [CHAR_W-1:0] CH_BACKSPACE  = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GET  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef struct packed {
        logic             is_hex;
        logic [NIB_W-1:0] nibble;
    } hex_char_t;

endpackage

// File: rtl/scan_hex_c2h.sv
// ASCII character to hex nibble decoder; accepts 0-9, A-F and a-f.
module scan_hex_c2h
    import scan_hex_pkg::*;
(
    input  logic [CHAR_W-1:0] ch,
    output hex_char_t         hex_c
);

    always_comb begin
        hex_c = '0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            hex_c.is_hex = 1'b1;
            hex_c.nibble = NIB_W'(ch - 8'h30);
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            hex_c.is_hex = 1'b1;
            hex_c.nibble = NIB_W'(ch - 8'h37);
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            hex_c.is_hex = 1'b1;
            hex_c.nibble = NIB_W'(ch - 8'h57);
        end
    end

endmodule

// File: rtl/scan_hex.sv
// Request-driven parser of UART characters into a raw byte or a hex word,
// returned on din_rx/err_rx with a one-cycle ack_rx pulse.
module scan_hex
    import scan_hex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CHAR_W-1:0] d_rx,
    input  logic              vld_rx,
    output logic              rdy_rx,
    input  logic              type_rx,
    input  logic              req_rx,
    output logic [DATA_W-1:0] din_rx,
    output logic              ack_rx,
    output logic              err_rx
);

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] acc_q, acc_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              err_q, err_nxt;
    logic              mode_q, mode_nxt;
    logic              req_d;
    logic [DATA_W-1:0] din_nxt;
    logic              err_out_nxt;
    logic              xfer;
    hex_char_t         hex_c;

    scan_hex_c2h u_c2h (
        .ch    (d_rx),
        .hex_c (hex_c)
    );

    assign xfer = vld_rx && rdy_rx;

    // State, accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
            req_d   <= 1'b0;
            din_rx  <= '0;
            err_rx  <= 1'b0;
            rdy_rx  <= 1'b0;
            ack_rx  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            acc_q   <= acc_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            mode_q  <= mode_nxt;
            req_d   <= req_rx;
            din_rx  <= din_nxt;
            err_rx  <= err_out_nxt;
            rdy_rx  <= (state_nxt == ST_GET);
            ack_rx  <= (state_nxt == ST_ACK);
        end
    end

    // Next-state and character handling
    always_comb begin
        state_nxt   = state_q;
        acc_nxt     = acc_q;
        cnt_nxt     = cnt_q;
        err_nxt     = err_q;
        mode_nxt    = mode_q;
        din_nxt     = din_rx;
        err_out_nxt = err_rx;
        case (state_q)
            ST_IDLE: begin
                if (req_rx && !req_d) begin
                    state_nxt = ST_GET;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    mode_nxt  = type_rx;
                end
            end
            ST_GET: begin
                if (!req_rx) begin
                    state_nxt = ST_IDLE;
                end else if (xfer) begin
                    if (!mode_q) begin
                        din_nxt     = {(DATA_W-CHAR_W)'(0), d_rx};
                        err_out_nxt = 1'b0;
                        state_nxt   = ST_ACK;
                    end else if (hex_c.is_hex) begin
                        if (cnt_q < DIGIT_MAX) begin
                            acc_nxt = {acc_q[DATA_W-NIB_W-1:0], hex_c.nibble};
                            cnt_nxt = cnt_q + CNT_W'(1);
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (d_rx == CH_UNDERSCORE) begin
                        err_nxt = err_q;
                    end else if (d_rx == CH_SPACE) begin
                        if (cnt_q != '0) begin
                            din_nxt     = acc_q;
                            err_out_nxt = err_q;
                            state_nxt   = ST_ACK;
                        end
                    end else if (d_rx == CH_CR) begin
                        din_nxt     = (cnt_q == '0) ? '0 : acc_q;
                        err_out_nxt = err_q || (cnt_q == '0);
                        state_nxt   = ST_ACK;
                    end else if (d_rx == CH_BACKSPACE) begin
                        if (cnt_q != '0) begin
                            acc_nxt = {NIB_W'(0), acc_q[DATA_W-1:NIB_W]};
                            cnt_nxt = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
